// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory-port arbiter: one-hot FSM
// state encoding and requester owner IDs.
package mem_arb_pkg;

   typedef enum logic [3:0] {
      IDLE = 4'b0001,
      REQ  = 4'b0010,
      RESP = 4'b0100,
      RET  = 4'b1000
   } arb_state_t;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the channel not served last wins.
module rr_arb2 (
   input  logic req_i,
   input  logic req_d,
   input  logic last_d,
   output logic gnt_i,
   output logic gnt_d
);

   assign gnt_d = req_d & (~req_i | ~last_d);
   assign gnt_i = req_i & (~req_d | last_d);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the fetch and load/store channels, one
// latched transaction at a time. Optional counters: MEM_ARB_PERF_CNT_EN.
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   i_pc,
   input  logic                i_req_valid,
   output logic                i_req_ready,
   output logic [DATA_W-1:0]   i_inst,
   output logic                i_inst_valid,
   input  logic                i_inst_ready,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic                d_memread,
   input  logic                d_memwrite,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic                d_req_ready,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_rdata_valid,
   input  logic                d_rdata_ready,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   output logic                m_memread,
   output logic                m_memwrite,
   input  logic                m_req_ready,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic                m_rdata_valid,
   output logic                m_rdata_ready,
   output logic [31:0]         perf_wait_cnt,
   output logic [31:0]         perf_grant_cnt
);

   localparam int STRB_W = DATA_W / 8;

   arb_state_t          state, state_nxt;
   logic                last_d;
   logic                gnt_i, gnt_d, grant;
   logic                lat_owner, lat_write;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata, resp_data;
   logic [STRB_W-1:0]   lat_wstrb;
   logic                owner_ready;

   rr_arb2 u_rr (
      .req_i  (i_req_valid),
      .req_d  (d_memread | d_memwrite),
      .last_d (last_d),
      .gnt_i  (gnt_i),
      .gnt_d  (gnt_d)
   );

   assign grant       = (state == IDLE) & (gnt_i | gnt_d);
   assign owner_ready = (lat_owner == OWN_D) ? d_rdata_ready : i_inst_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Every output is decoded from state so non-active phases drive zero.
   always_comb begin
      state_nxt     = state;
      i_req_ready   = 1'b0;
      d_req_ready   = 1'b0;
      m_addr        = '0;
      m_wdata       = '0;
      m_wstrb       = '0;
      m_memread     = 1'b0;
      m_memwrite    = 1'b0;
      m_rdata_ready = 1'b0;
      i_inst        = '0;
      i_inst_valid  = 1'b0;
      d_rdata       = '0;
      d_rdata_valid = 1'b0;
      case (state)
         IDLE: begin
            i_req_ready = gnt_i;
            d_req_ready = gnt_d;
            if (gnt_i | gnt_d) state_nxt = REQ;
         end
         REQ: begin
            m_addr     = lat_addr;
            m_wdata    = lat_wdata;
            m_wstrb    = lat_wstrb;
            m_memread  = ~lat_write;
            m_memwrite = lat_write;
            if (m_req_ready) state_nxt = lat_write ? IDLE : RESP;
         end
         RESP: begin
            m_rdata_ready = 1'b1;
            if (m_rdata_valid) state_nxt = RET;
         end
         RET: begin
            if (lat_owner == OWN_D) begin
               d_rdata       = resp_data;
               d_rdata_valid = 1'b1;
            end else begin
               i_inst       = resp_data;
               i_inst_valid = 1'b1;
            end
            if (owner_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A load/store with both op bits set is treated as a store.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lat_owner <= OWN_I;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_wstrb <= '0;
         resp_data <= '0;
         last_d    <= 1'b0;
      end else begin
         if (grant) begin
            lat_owner <= gnt_d ? OWN_D : OWN_I;
            lat_write <= gnt_d & d_memwrite;
            lat_addr  <= gnt_d ? d_addr : i_pc;
            lat_wdata <= gnt_d ? d_wdata : '0;
            lat_wstrb <= (gnt_d & d_memwrite) ? d_wstrb : '0;
         end
         if (state == RESP && m_rdata_valid) resp_data <= m_rdata;
         if ((state == RET && owner_ready) || (state == REQ && m_req_ready && lat_write))
            last_d <= lat_owner;
      end
   end

`ifdef MEM_ARB_PERF_CNT_EN
   logic [31:0] wait_q, grant_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_q  <= '0;
         grant_q <= '0;
      end else begin
         if ((state == REQ && !m_req_ready) || (state == RESP && !m_rdata_valid))
            wait_q <= wait_q + 32'd1;
         if (grant) grant_q <= grant_q + 32'd1;
      end
   end

   assign perf_wait_cnt  = wait_q;
   assign perf_grant_cnt = grant_q;
`else
   assign perf_wait_cnt  = '0;
   assign perf_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, store, tie-break, backpressure,
// reset mid-transaction and owner hold.
module tb_mem_bus_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic [ADDR_W-1:0]   i_pc = '0;
   logic                i_req_valid = 1'b0;
   logic                i_req_ready;
   logic [DATA_W-1:0]   i_inst;
   logic                i_inst_valid;
   logic                i_inst_ready = 1'b0;
   logic [ADDR_W-1:0]   d_addr = '0;
   logic                d_memread = 1'b0;
   logic                d_memwrite = 1'b0;
   logic [DATA_W-1:0]   d_wdata = '0;
   logic [DATA_W/8-1:0] d_wstrb = '0;
   logic                d_req_ready;
   logic [DATA_W-1:0]   d_rdata;
   logic                d_rdata_valid;
   logic                d_rdata_ready = 1'b0;
   logic [ADDR_W-1:0]   m_addr;
   logic [DATA_W-1:0]   m_wdata;
   logic [DATA_W/8-1:0] m_wstrb;
   logic                m_memread;
   logic                m_memwrite;
   logic                m_req_ready = 1'b0;
   logic [DATA_W-1:0]   m_rdata = '0;
   logic                m_rdata_valid = 1'b0;
   logic                m_rdata_ready;
   logic [31:0]         perf_wait_cnt;
   logic [31:0]         perf_grant_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] exp_w;
   logic [31:0] exp_wait, exp_grant;

   mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst),
      .i_pc(i_pc), .i_req_valid(i_req_valid), .i_req_ready(i_req_ready),
      .i_inst(i_inst), .i_inst_valid(i_inst_valid), .i_inst_ready(i_inst_ready),
      .d_addr(d_addr), .d_memread(d_memread), .d_memwrite(d_memwrite),
      .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_req_ready(d_req_ready),
      .d_rdata(d_rdata), .d_rdata_valid(d_rdata_valid), .d_rdata_ready(d_rdata_ready),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_memread(m_memread), .m_memwrite(m_memwrite), .m_req_ready(m_req_ready),
      .m_rdata(m_rdata), .m_rdata_valid(m_rdata_valid), .m_rdata_ready(m_rdata_ready),
      .perf_wait_cnt(perf_wait_cnt), .perf_grant_cnt(perf_grant_cnt)
   );

   // Clock / reset
   always #5 clk = ~clk;

   // Driver tasks: inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      i_req_valid = 1'b0; d_memread = 1'b0; d_memwrite = 1'b0;
      i_inst_ready = 1'b0; d_rdata_ready = 1'b0;
      m_req_ready = 1'b0; m_rdata_valid = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (i_req_ready !== 1'b0 || d_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got i=%b d=%b exp 0 0", i_req_ready, d_req_ready); end
      n_checks++; if ({m_memread, m_memwrite, m_rdata_ready, i_inst_valid, d_rdata_valid} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b exp 00000", {m_memread, m_memwrite, m_rdata_ready, i_inst_valid, d_rdata_valid}); end
      n_checks++; if (m_addr !== '0 || m_wdata !== '0 || m_wstrb !== '0) begin n_fail++; $display("FAIL reset_payload: got %h %h %h exp 0", m_addr, m_wdata, m_wstrb); end
      n_checks++; if (perf_wait_cnt !== 32'd0 || perf_grant_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_perf: got %0d %0d exp 0 0", perf_wait_cnt, perf_grant_cnt); end
   endtask

   task automatic test_fetch();
      i_pc = 32'h100; i_req_valid = 1'b1; m_req_ready = 1'b1;
      #1;
      n_checks++; if (i_req_ready !== 1'b1 || d_req_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_accept: got i=%b d=%b exp 1 0", i_req_ready, d_req_ready); end
      tick();
      i_req_valid = 1'b0;
      #1;
      n_checks++; if (m_memread !== 1'b1 || m_memwrite !== 1'b0 || m_addr !== 32'h100 || m_wstrb !== 4'h0) begin n_fail++; $display("FAIL fetch_req: got rd=%b wr=%b addr=%h strb=%h exp 1 0 100 0", m_memread, m_memwrite, m_addr, m_wstrb); end
      n_checks++; if (i_req_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_ready_pulse: got %b exp 0", i_req_ready); end
      tick();
      n_checks++; if (m_rdata_ready !== 1'b1 || m_memread !== 1'b0) begin n_fail++; $display("FAIL fetch_resp: got rdy=%b rd=%b exp 1 0", m_rdata_ready, m_memread); end
      m_rdata = 32'h0050_0093; m_rdata_valid = 1'b1; exp_q.push_back(32'h0050_0093);
      tick();
      m_rdata_valid = 1'b0; i_inst_ready = 1'b1;
      #1;
      exp_w = exp_q.pop_front();
      n_checks++; if (i_inst_valid !== 1'b1 || i_inst !== exp_w) begin n_fail++; $display("FAIL fetch_ret: got v=%b inst=%h exp 1 %h", i_inst_valid, i_inst, exp_w); end
      n_checks++; if (d_rdata_valid !== 1'b0 || m_rdata_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_nonowner: got dv=%b rr=%b exp 0 0", d_rdata_valid, m_rdata_ready); end
      tick();
      i_inst_ready = 1'b0;
      n_checks++; if (i_inst_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_done: got %b exp 0", i_inst_valid); end
   endtask

   task automatic test_store();
      d_addr = 32'h204; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b1100; d_memwrite = 1'b1; m_req_ready = 1'b1;
      #1;
      n_checks++; if (d_req_ready !== 1'b1 || i_req_ready !== 1'b0) begin n_fail++; $display("FAIL store_accept: got d=%b i=%b exp 1 0", d_req_ready, i_req_ready); end
      tick();
      d_memwrite = 1'b0;
      #1;
      n_checks++; if (m_memwrite !== 1'b1 || m_memread !== 1'b0 || m_addr !== 32'h204 || m_wdata !== 32'hDEAD_BEEF || m_wstrb !== 4'b1100) begin n_fail++; $display("FAIL store_req: got wr=%b rd=%b %h %h %b exp 1 0 204 deadbeef 1100", m_memwrite, m_memread, m_addr, m_wdata, m_wstrb); end
      tick();
      n_checks++; if (m_memwrite !== 1'b0 || d_rdata_valid !== 1'b0 || m_rdata_ready !== 1'b0) begin n_fail++; $display("FAIL store_done: got wr=%b dv=%b rr=%b exp 0 0 0", m_memwrite, d_rdata_valid, m_rdata_ready); end
      // Both op bits high is handled as a store.
      d_addr = 32'h208; d_wdata = 32'h1234_5678; d_wstrb = 4'b0011; d_memread = 1'b1; d_memwrite = 1'b1;
      #1;
      n_checks++; if (d_req_ready !== 1'b1) begin n_fail++; $display("FAIL store_idle_after2: got %b exp 1", d_req_ready); end
      tick();
      d_memread = 1'b0; d_memwrite = 1'b0;
      #1;
      n_checks++; if (m_memwrite !== 1'b1 || m_memread !== 1'b0 || m_wstrb !== 4'b0011) begin n_fail++; $display("FAIL illegal_as_write: got wr=%b rd=%b strb=%b exp 1 0 0011", m_memwrite, m_memread, m_wstrb); end
      tick();
      n_checks++; if (d_rdata_valid !== 1'b0 || m_rdata_ready !== 1'b0) begin n_fail++; $display("FAIL illegal_no_resp: got dv=%b rr=%b exp 0 0", d_rdata_valid, m_rdata_ready); end
   endtask

   task automatic test_tie_break();
      do_reset();
      i_pc = 32'h104; i_req_valid = 1'b1;
      d_addr = 32'h300; d_memread = 1'b1; m_req_ready = 1'b1;
      #1;
      n_checks++; if (d_req_ready !== 1'b1 || i_req_ready !== 1'b0) begin n_fail++; $display("FAIL tie1_grant: got d=%b i=%b exp 1 0", d_req_ready, i_req_ready); end
      tick();
      d_memread = 1'b0;
      #1;
      n_checks++; if (m_addr !== 32'h300 || m_memread !== 1'b1 || i_req_ready !== 1'b0) begin n_fail++; $display("FAIL tie1_req: got addr=%h rd=%b irdy=%b exp 300 1 0", m_addr, m_memread, i_req_ready); end
      tick();
      m_rdata = 32'h1111_2222; m_rdata_valid = 1'b1; exp_q.push_back(32'h1111_2222);
      tick();
      m_rdata_valid = 1'b0; d_rdata_ready = 1'b1;
      d_addr = 32'h308; d_memread = 1'b1;
      #1;
      exp_w = exp_q.pop_front();
      n_checks++; if (d_rdata_valid !== 1'b1 || d_rdata !== exp_w || i_inst_valid !== 1'b0 || i_inst !== '0) begin n_fail++; $display("FAIL tie1_ret: got dv=%b d=%h iv=%b i=%h exp 1 %h 0 0", d_rdata_valid, d_rdata, i_inst_valid, i_inst, exp_w); end
      n_checks++; if (d_req_ready !== 1'b0) begin n_fail++; $display("FAIL tie_ret_no_accept: got %b exp 0", d_req_ready); end
      tick();
      d_rdata_ready = 1'b0;
      n_checks++; if (i_req_ready !== 1'b1 || d_req_ready !== 1'b0) begin n_fail++; $display("FAIL tie2_grant: got i=%b d=%b exp 1 0", i_req_ready, d_req_ready); end
      tick();
      i_req_valid = 1'b0;
      #1;
      n_checks++; if (m_addr !== 32'h104 || m_memread !== 1'b1) begin n_fail++; $display("FAIL tie2_req: got addr=%h rd=%b exp 104 1", m_addr, m_memread); end
      tick();
      m_rdata = 32'hAAAA_0001; m_rdata_valid = 1'b1; exp_q.push_back(32'hAAAA_0001);
      tick();
      m_rdata_valid = 1'b0; i_inst_ready = 1'b1;
      #1;
      exp_w = exp_q.pop_front();
      n_checks++; if (i_inst_valid !== 1'b1 || i_inst !== exp_w || d_rdata_valid !== 1'b0) begin n_fail++; $display("FAIL tie2_ret: got iv=%b i=%h dv=%b exp 1 %h 0", i_inst_valid, i_inst, d_rdata_valid, exp_w); end
      tick();
      i_inst_ready = 1'b0;
      n_checks++; if (d_req_ready !== 1'b1) begin n_fail++; $display("FAIL tie3_data_grant: got %b exp 1", d_req_ready); end
      tick();
      d_memread = 1'b0;
   endtask

   task automatic test_backpressure();
      do_reset();
`ifdef MEM_ARB_PERF_CNT_EN
      exp_wait = 32'd5; exp_grant = 32'd1;
`else
      exp_wait = 32'd0; exp_grant = 32'd0;
`endif
      i_pc = 32'h400; i_req_valid = 1'b1; m_req_ready = 1'b0;
      tick();
      i_req_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_checks++; if (m_addr !== 32'h400 || m_memread !== 1'b1 || m_wstrb !== 4'h0) begin n_fail++; $display("FAIL bp_hold_req%0d: got addr=%h rd=%b exp 400 1", k, m_addr, m_memread); end
         tick();
      end
      m_req_ready = 1'b1;
      tick();
      m_req_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         n_checks++; if (m_rdata_ready !== 1'b1 || m_memread !== 1'b0) begin n_fail++; $display("FAIL bp_hold_resp%0d: got rr=%b rd=%b exp 1 0", k, m_rdata_ready, m_memread); end
         tick();
      end
      m_rdata = 32'hCAFE_0400; m_rdata_valid = 1'b1; exp_q.push_back(32'hCAFE_0400);
      tick();
      m_rdata_valid = 1'b0;
      #1;
      exp_w = exp_q.pop_front();
      n_checks++; if (i_inst_valid !== 1'b1 || i_inst !== exp_w) begin n_fail++; $display("FAIL bp_ret: got v=%b i=%h exp 1 %h", i_inst_valid, i_inst, exp_w); end
      n_checks++; if (perf_wait_cnt !== exp_wait) begin n_fail++; $display("FAIL bp_perf_wait: got %0d exp %0d", perf_wait_cnt, exp_wait); end
      n_checks++; if (perf_grant_cnt !== exp_grant) begin n_fail++; $display("FAIL bp_perf_grant: got %0d exp %0d", perf_grant_cnt, exp_grant); end
      i_inst_ready = 1'b1;
      tick();
      i_inst_ready = 1'b0;
   endtask

   task automatic test_reset_in_resp();
      do_reset();
      i_pc = 32'h500; i_req_valid = 1'b1; m_req_ready = 1'b1;
      tick();
      i_req_valid = 1'b0;
      tick();
      n_checks++; if (m_rdata_ready !== 1'b1) begin n_fail++; $display("FAIL rr_in_resp: got %b exp 1", m_rdata_ready); end
      #2 rst = 1'b0;
      #1;
      n_checks++; if ({m_rdata_ready, m_memread, m_memwrite, i_inst_valid, d_rdata_valid, i_req_ready, d_req_ready} !== 7'b0 || m_addr !== '0) begin n_fail++; $display("FAIL rr_async_reset: got %b addr=%h exp 0", {m_rdata_ready, m_memread, m_memwrite, i_inst_valid, d_rdata_valid, i_req_ready, d_req_ready}, m_addr); end
      @(posedge clk);
      #1 rst = 1'b1;
      m_rdata = 32'hBAD0_BAD0; m_rdata_valid = 1'b1;
      tick();
      m_rdata_valid = 1'b0;
      #1;
      n_checks++; if (i_inst_valid !== 1'b0 || m_rdata_ready !== 1'b0) begin n_fail++; $display("FAIL rr_late_rdata: got iv=%b rr=%b exp 0 0", i_inst_valid, m_rdata_ready); end
      i_pc = 32'h504; i_req_valid = 1'b1;
      #1;
      n_checks++; if (i_req_ready !== 1'b1) begin n_fail++; $display("FAIL rr_new_accept: got %b exp 1", i_req_ready); end
      tick();
      i_req_valid = 1'b0;
      #1;
      n_checks++; if (m_addr !== 32'h504 || m_memread !== 1'b1) begin n_fail++; $display("FAIL rr_new_req: got addr=%h rd=%b exp 504 1", m_addr, m_memread); end
      tick();
      m_rdata = 32'h0000_0513; m_rdata_valid = 1'b1; exp_q.push_back(32'h0000_0513);
      tick();
      m_rdata_valid = 1'b0; i_inst_ready = 1'b1;
      #1;
      exp_w = exp_q.pop_front();
      n_checks++; if (i_inst_valid !== 1'b1 || i_inst !== exp_w) begin n_fail++; $display("FAIL rr_new_ret: got v=%b i=%h exp 1 %h", i_inst_valid, i_inst, exp_w); end
      tick();
      i_inst_ready = 1'b0;
   endtask

   task automatic test_owner_hold();
      do_reset();
      i_pc = 32'h600; i_req_valid = 1'b1; m_req_ready = 1'b1;
      tick();
      i_req_valid = 1'b0;
      d_addr = 32'h700; d_memread = 1'b1;
      tick();
      m_rdata = 32'h0123_4567; m_rdata_valid = 1'b1; exp_q.push_back(32'h0123_4567);
      tick();
      m_rdata_valid = 1'b0; m_rdata = 32'hFFFF_FFFF;
      exp_w = exp_q.pop_front();
      for (int k = 0; k < 4; k++) begin
         #1;
         n_checks++; if (i_inst_valid !== 1'b1 || i_inst !== exp_w || d_req_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ret%0d: got iv=%b i=%h drdy=%b exp 1 %h 0", k, i_inst_valid, i_inst, d_req_ready, exp_w); end
         tick();
      end
      i_inst_ready = 1'b1;
      tick();
      i_inst_ready = 1'b0;
      n_checks++; if (d_req_ready !== 1'b1 || i_inst_valid !== 1'b0) begin n_fail++; $display("FAIL hold_data_grant: got drdy=%b iv=%b exp 1 0", d_req_ready, i_inst_valid); end
      tick();
      d_memread = 1'b0;
      #1;
      n_checks++; if (m_addr !== 32'h700 || m_memread !== 1'b1) begin n_fail++; $display("FAIL hold_data_req: got addr=%h rd=%b exp 700 1", m_addr, m_memread); end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_store();
      test_tie_break();
      test_backpressure();
      test_reset_in_resp();
      test_owner_hold();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog: every scenario is a fixed cycle count, so this only trips on a bench stall.
   initial begin
      #20000;
      $display("FAIL watchdog: got timeout exp completion");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester arbiter that shares one memory port between the CPU's instruction-fetch channel and its data load/store channel. It sits between `custom_cpu` and the memory subsystem, so a single-ported memory serves both channels. Each granted transaction is latched and replayed on the downstream valid/ready channels, and read data is routed back to the requester that issued it. Requesters are served round-robin, one transaction at a time.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; the strobe width is `DATA_W/8`.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: asynchronous, active-low reset.
- `i_pc`  in  ADDR_W: fetch address.
- `i_req_valid`  in  1: fetch request valid.
- `i_req_ready`  out  1: fetch request accepted.
- `i_inst`  out  DATA_W: returned instruction word.
- `i_inst_valid`  out  1: instruction valid.
- `i_inst_ready`  in  1: CPU takes the instruction.
- `d_addr`  in  ADDR_W: data address.
- `d_memread`  in  1: load request.
- `d_memwrite`  in  1: store request.
- `d_wdata`  in  DATA_W: store data.
- `d_wstrb`  in  DATA_W/8: store byte strobes.
- `d_req_ready`  out  1: data request accepted.
- `d_rdata`  out  DATA_W: load data.
- `d_rdata_valid`  out  1: load data valid.
- `d_rdata_ready`  in  1: CPU takes the load data.
- `m_addr`, `m_wdata`, `m_wstrb`, `m_memread`, `m_memwrite`  out: downstream request payload.
- `m_req_ready`  in  1: downstream request accepted.
- `m_rdata`  in  DATA_W: downstream read data.
- `m_rdata_valid`  in  1: downstream read data valid.
- `m_rdata_ready`  out  1: arbiter takes the read data.
- `perf_wait_cnt`, `perf_grant_cnt`  out  32: performance counters.

## Operation
- FSM states: `IDLE`, `REQ`, `RESP`, `RET`.
- `IDLE`
  - The data channel is requesting when `d_memread | d_memwrite`; the fetch channel is requesting when `i_req_valid`.
  - If only one channel requests, grant it.
  - If both request, grant the channel not served last (`last_d` flag; reset value 0, so data wins the first tie).
  - In the grant cycle: pulse the granted `*_req_ready` high combinationally, latch addr/wdata/wstrb/op/owner, go to `REQ`.
- `REQ`
  - Drive `m_*` from the latched payload.
  - On `m_req_ready`: a write goes to `IDLE`; a read goes to `RESP`.
- `RESP`
  - Hold `m_rdata_ready = 1`.
  - On `m_rdata_valid`, capture `m_rdata` into the response register and go to `RET`.
- `RET`
  - Assert the owner's `*_valid` with the response register on its data port.
  - On the owner's ready, go to `IDLE` and update `last_d`.
- `d_memread` and `d_memwrite` both high is illegal. The arbiter treats it as a write and does not assert.
- A fetch is always a read with `m_wstrb = 0`.
- No request is accepted outside `IDLE`. Upstream valids are ignored there, and requesters must hold their payload stable until they see ready.

## Timing
- Reset (async assert, sync deassert):
  - State goes to `IDLE`.
  - All outputs are 0: ready, valid, `m_*` and the counters.
  - `last_d` = 0.
  - An in-flight downstream transaction is abandoned and not replayed.
- Read latency with a zero-wait memory: accept at cycle 0, `REQ` at cycle 1, `RESP` at cycle 2, owner valid at cycle 3. Minimum is 4 cycles per read, 2 per write.
- `m_memread`/`m_memwrite` are high only in `REQ`.
- `m_rdata_ready` is high only in `RESP`.
- `i_inst_valid` / `d_rdata_valid` are high only in `RET` for the owner; the non-owner output stays 0.
- Upstream ready pulses last exactly one cycle per grant.
- A request raised in the cycle the FSM returns to `IDLE` is granted in that same `IDLE` cycle.

## Configuration
- Macro: `MEM_ARB_PERF_CNT_EN`.
- Defined:
  - `perf_wait_cnt` increments each cycle in `REQ` or `RESP` where the awaited downstream handshake does not complete.
  - `perf_grant_cnt` increments on each grant.
  - Both wrap at 2^32.
- Undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- Package `mem_arb_pkg` holds:
  - the state encoding (one-hot, 4 bits);
  - owner IDs `OWN_I = 1'b0` and `OWN_D = 1'b1`.
- Sub-module `rr_arb2`: a 2-way round-robin picker. Inputs are the two request lines and `last_d`; output is the grant.
- FSM, payload/response registers and counters live in the top module.

## Test plan
- Single fetch: `i_pc = 0x100`, zero-wait memory returns `0x00500093` → `i_req_ready` pulses at cycle 0, `m_addr = 0x100` with `m_memread = 1` at cycle 1, `i_inst = 0x00500093` with `i_inst_valid` at cycle 3.
- Store: `d_addr = 0x204`, `d_wdata = 0xDEADBEEF`, `d_wstrb = 4'b1100` → one `m_memwrite` beat with an identical payload, back in `IDLE` 2 cycles after accept, `d_rdata_valid` never asserts.
- Simultaneous fetch and load from reset → data is granted first; fetch is granted in the next `IDLE`; the next tie goes to the fetch channel.
- Backpressure: `m_req_ready` low for 3 cycles, then `m_rdata_valid` after 2 more, with `MEM_ARB_PERF_CNT_EN` defined → payload held stable throughout, `perf_wait_cnt` = 5, `perf_grant_cnt` = 1.
- Reset asserted in `RESP` → outputs 0 immediately. After release, a new fetch completes normally and a late `m_rdata_valid` pulse is ignored in `IDLE`.
- Owner hold: `i_inst_ready` held low for 4 cycles in `RET` → `i_inst` stable and `i_inst_valid` high for all 4 cycles, and a pending data request is not accepted until the FSM returns to `IDLE`.
